// File: rtl/timer_counter_param.sv
// Parametrised timer/counter (normal, CTC, fast PWM) with 10-bit prescaler, external clock source and compare pin.
// Outputs registered; flags visible the cycle after a tick; register writes are single-cycle enables with no backpressure.
module timer_counter_param #(
  parameter int WIDTH       = 8,
  parameter bit PRESC_RESET = 1'b1
) (
  input  logic             sysClock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] TCNT_input,
  input  logic [WIDTH-1:0] OCR_input,
  input  logic [7:0]       TCCR_input,
  input  logic [1:0]       TIMSK_input,
  input  logic [1:0]       TIFR_input,
  input  logic             TCNT_write_enable,
  input  logic             OCR_write_enable,
  input  logic             TCCR_write_enable,
  input  logic             TIMSK_write_enable,
  input  logic             TIFR_write_enable,
  input  logic             clear_count,
  input  logic             ext_clk_pin,
  output logic [WIDTH-1:0] TCNT_output,
  output logic [WIDTH-1:0] OCR_output,
  output logic [7:0]       TCCR_output,
  output logic [1:0]       TIMSK_output,
  output logic [1:0]       TIFR_output,
  output logic             irq_ovf,
  output logic             irq_cmp,
  output logic             oc_pin
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] tcnt_q, ocr_q, ocr_buf_q;
  logic [6:0]       tccr_q;
  logic [1:0]       timsk_q, tifr_q;
  logic [9:0]       presc_q;
  logic [2:0]       ext_sync_q;
  logic             blk_q, oc_q;

  logic [2:0] cs;
  logic [1:0] com;
  logic       pwm_mode, ctc_mode;
  logic       ext_rise, ext_fall, presc_run;
  logic       tick_raw, tick, match, wrap, ctc_clear, foc, oc_d;

  assign cs        = tccr_q[2:0];
  assign com       = tccr_q[6:5];
  assign pwm_mode  = (tccr_q[4:3] == 2'b10);
  assign ctc_mode  = (tccr_q[4:3] == 2'b01);
  assign ext_rise  = ext_sync_q[1] & ~ext_sync_q[2];
  assign ext_fall  = ~ext_sync_q[1] & ext_sync_q[2];
  assign presc_run = (cs >= 3'd1) && (cs <= 3'd5);

  always_comb begin
    tick_raw = 1'b0;
    case (cs)
      3'd1:    tick_raw = 1'b1;
      3'd2:    tick_raw = &presc_q[2:0];
      3'd3:    tick_raw = &presc_q[5:0];
      3'd4:    tick_raw = &presc_q[7:0];
      3'd5:    tick_raw = &presc_q;
      3'd6:    tick_raw = ext_fall;
      3'd7:    tick_raw = ext_rise;
      default: tick_raw = 1'b0;
    endcase
  end

  // A tick colliding with a clear or a software TCNT write is dropped entirely.
  assign tick      = tick_raw & ~clear_count & ~TCNT_write_enable;
  assign match     = tick & ~blk_q & (tcnt_q == ocr_q);
  assign wrap      = tick & (tcnt_q == CNT_MAX);
  assign ctc_clear = ctc_mode & match;
  assign foc       = TCCR_write_enable & TCCR_input[7] & (TCCR_input[4:3] != 2'b10);

  function automatic logic com_apply(input logic [1:0] c, input logic cur);
    case (c)
      2'b01:   return ~cur;
      2'b10:   return 1'b0;
      2'b11:   return 1'b1;
      default: return cur;
    endcase
  endfunction

  always_comb begin
    oc_d = oc_q;
    if (foc) begin
      oc_d = com_apply(TCCR_input[6:5], oc_q);
    end else if (pwm_mode) begin
      // BOTTOM wins over a match at MAX so OCR=MAX gives a constant level.
      if (com[1]) begin
        if (wrap)       oc_d = ~com[0];
        else if (match) oc_d = com[0];
      end
    end else if (match) begin
      oc_d = com_apply(com, oc_q);
    end
  end

  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q     <= '0;
      ocr_q      <= '0;
      ocr_buf_q  <= '0;
      tccr_q     <= '0;
      timsk_q    <= '0;
      tifr_q     <= '0;
      presc_q    <= '0;
      ext_sync_q <= '0;
      blk_q      <= 1'b0;
      oc_q       <= 1'b0;
    end else begin
      ext_sync_q <= {ext_sync_q[1:0], ext_clk_pin};
      oc_q       <= oc_d;

      if (clear_count || (TCCR_write_enable && PRESC_RESET)) presc_q <= '0;
      else if (presc_run)                                    presc_q <= presc_q + 10'd1;

      if (clear_count)            tcnt_q <= '0;
      else if (TCNT_write_enable) tcnt_q <= TCNT_input;
      else if (tick)              tcnt_q <= ctc_clear ? '0 : tcnt_q + CNT_ONE;

      if (TCNT_write_enable) blk_q <= 1'b1;
      else if (tick)         blk_q <= 1'b0;

      if (OCR_write_enable) begin
        ocr_buf_q <= OCR_input;
        if (!pwm_mode) ocr_q <= OCR_input;
      end
      if (pwm_mode && wrap) ocr_q <= OCR_write_enable ? OCR_input : ocr_buf_q;

      if (TCCR_write_enable)  tccr_q  <= TCCR_input[6:0];
      if (TIMSK_write_enable) timsk_q <= TIMSK_input;

      tifr_q[0] <= wrap  | (tifr_q[0] & ~(TIFR_write_enable & TIFR_input[0]));
      tifr_q[1] <= match | (tifr_q[1] & ~(TIFR_write_enable & TIFR_input[1]));
    end
  end

  assign TCNT_output  = tcnt_q;
  assign OCR_output   = ocr_q;
  assign TCCR_output  = {1'b0, tccr_q};
  assign TIMSK_output = timsk_q;
  assign TIFR_output  = tifr_q;
  assign oc_pin       = oc_q;
  assign irq_ovf      = tifr_q[0] & timsk_q[0];
  assign irq_cmp      = tifr_q[1] & timsk_q[1];

endmodule

// File: tb/tb_timer_counter_param.sv
// Directed bench: 8-bit and 16-bit instances driven by one shared register-write bus.
module tb_timer_counter_param;

  logic        sysClock = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tcnt_in = '0, ocr_in = '0;
  logic [7:0]  tccr_in = '0;
  logic [1:0]  timsk_in = '0, tifr_in = '0;
  logic        tcnt_we = 0, ocr_we = 0, tccr_we = 0, timsk_we = 0, tifr_we = 0;
  logic        clear_count = 0, ext_pin = 0;

  logic [7:0]  tcnt8, ocr8, tccr8;
  logic [1:0]  timsk8, tifr8;
  logic        irq_ovf8, irq_cmp8, oc8;
  logic [15:0] tcnt16, ocr16;
  logic [7:0]  tccr16;
  logic [1:0]  timsk16, tifr16;
  logic        irq_ovf16, irq_cmp16, oc16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sysClock = ~sysClock;

  timer_counter_param #(.WIDTH(8), .PRESC_RESET(1'b1)) u8 (
    .sysClock(sysClock), .rst_n(rst_n),
    .TCNT_input(tcnt_in[7:0]), .OCR_input(ocr_in[7:0]), .TCCR_input(tccr_in),
    .TIMSK_input(timsk_in), .TIFR_input(tifr_in),
    .TCNT_write_enable(tcnt_we), .OCR_write_enable(ocr_we), .TCCR_write_enable(tccr_we),
    .TIMSK_write_enable(timsk_we), .TIFR_write_enable(tifr_we),
    .clear_count(clear_count), .ext_clk_pin(ext_pin),
    .TCNT_output(tcnt8), .OCR_output(ocr8), .TCCR_output(tccr8),
    .TIMSK_output(timsk8), .TIFR_output(tifr8),
    .irq_ovf(irq_ovf8), .irq_cmp(irq_cmp8), .oc_pin(oc8)
  );

  timer_counter_param #(.WIDTH(16), .PRESC_RESET(1'b1)) u16 (
    .sysClock(sysClock), .rst_n(rst_n),
    .TCNT_input(tcnt_in), .OCR_input(ocr_in), .TCCR_input(tccr_in),
    .TIMSK_input(timsk_in), .TIFR_input(tifr_in),
    .TCNT_write_enable(tcnt_we), .OCR_write_enable(ocr_we), .TCCR_write_enable(tccr_we),
    .TIMSK_write_enable(timsk_we), .TIFR_write_enable(tifr_we),
    .clear_count(clear_count), .ext_clk_pin(ext_pin),
    .TCNT_output(tcnt16), .OCR_output(ocr16), .TCCR_output(tccr16),
    .TIMSK_output(timsk16), .TIFR_output(tifr16),
    .irq_ovf(irq_ovf16), .irq_cmp(irq_cmp16), .oc_pin(oc16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sysClock);
      #1;
    end
  endtask

  task automatic wr_tcnt(input logic [15:0] v);
    tcnt_in = v; tcnt_we = 1'b1; cyc(1); tcnt_we = 1'b0;
  endtask

  task automatic wr_ocr(input logic [15:0] v);
    ocr_in = v; ocr_we = 1'b1; cyc(1); ocr_we = 1'b0;
  endtask

  task automatic wr_tccr(input logic [7:0] v);
    tccr_in = v; tccr_we = 1'b1; cyc(1); tccr_we = 1'b0;
  endtask

  task automatic wr_timsk(input logic [1:0] v);
    timsk_in = v; timsk_we = 1'b1; cyc(1); timsk_we = 1'b0;
  endtask

  task automatic wr_tifr(input logic [1:0] v);
    tifr_in = v; tifr_we = 1'b1; cyc(1); tifr_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tcnt_we = 0; ocr_we = 0; tccr_we = 0; timsk_we = 0; tifr_we = 0;
    clear_count = 0; ext_pin = 0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic check_all_zero8(input string tag);
    check_eq({tag, " tcnt"},  32'(tcnt8),    32'h0);
    check_eq({tag, " ocr"},   32'(ocr8),     32'h0);
    check_eq({tag, " tccr"},  32'(tccr8),    32'h0);
    check_eq({tag, " timsk"}, 32'(timsk8),   32'h0);
    check_eq({tag, " tifr"},  32'(tifr8),    32'h0);
    check_eq({tag, " irqo"},  32'(irq_ovf8), 32'h0);
    check_eq({tag, " irqc"},  32'(irq_cmp8), 32'h0);
    check_eq({tag, " oc"},    32'(oc8),      32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    int seq[5];
    seq = '{0, 1, 2, 3, 0};

    // Reset values and CS=0 freeze
    do_reset();
    check_all_zero8("rst");
    check_eq("rst tcnt16", 32'(tcnt16), 32'h0);
    cyc(5);
    check_eq("cs0 frozen", 32'(tcnt8), 32'h0);

    // 1: 8-bit normal-mode wrap, TOV, mask and W1C
    wr_tcnt(16'h00FE);
    check_eq("t1 wr", 32'(tcnt8), 32'hFE);
    wr_tccr(8'h01);
    check_eq("t1 tccr", 32'(tccr8), 32'h01);
    check_eq("t1 no tick on write", 32'(tcnt8), 32'hFE);
    cyc(1);
    check_eq("t1 ff", 32'(tcnt8), 32'hFF);
    check_eq("t1 tov0", 32'(tifr8[0]), 32'h0);
    cyc(1);
    check_eq("t1 wrap", 32'(tcnt8), 32'h00);
    check_eq("t1 tov1", 32'(tifr8[0]), 32'h1);
    check_eq("t1 irq masked", 32'(irq_ovf8), 32'h0);
    wr_timsk(2'b01);
    check_eq("t1 irq_ovf", 32'(irq_ovf8), 32'h1);
    wr_tifr(2'b01);
    check_eq("t1 tov clr", 32'(tifr8[0]), 32'h0);
    check_eq("t1 irq clr", 32'(irq_ovf8), 32'h0);

    // 2: 16-bit CTC with /8 prescaler
    do_reset();
    wr_ocr(16'd3);
    check_eq("t2 ocr", 32'(ocr16), 32'd3);
    wr_timsk(2'b10);
    wr_tccr(8'h0A);
    for (int k = 0; k < 4; k++) begin
      cyc(7);
      check_eq($sformatf("t2 hold%0d", k), 32'(tcnt16), 32'(seq[k]));
      if (k < 3) check_eq($sformatf("t2 ocf0_%0d", k), 32'(tifr16), 32'h0);
      cyc(1);
      check_eq($sformatf("t2 step%0d", k), 32'(tcnt16), 32'(seq[k+1]));
    end
    check_eq("t2 tifr", 32'(tifr16), 32'h2);
    check_eq("t2 irq_cmp", 32'(irq_cmp16), 32'h1);
    check_eq("t2 irq_ovf", 32'(irq_ovf16), 32'h0);

    // 3: 8-bit fast PWM, non-inverting, buffered OCR
    do_reset();
    wr_ocr(16'h0040);
    wr_tccr(8'h51);
    cyc(256);
    check_eq("t3 bottom", 32'(tcnt8), 32'h00);
    check_eq("t3 oc set", 32'(oc8), 32'h1);
    check_eq("t3 tov", 32'(tifr8[0]), 32'h1);
    cyc(64);
    check_eq("t3 at 40", 32'(tcnt8), 32'h40);
    check_eq("t3 oc hi", 32'(oc8), 32'h1);
    cyc(1);
    check_eq("t3 oc clr", 32'(oc8), 32'h0);
    wr_ocr(16'h0080);
    check_eq("t3 ocr buffered", 32'(ocr8), 32'h40);
    cyc(189);
    check_eq("t3 at ff", 32'(tcnt8), 32'hFF);
    check_eq("t3 ocr still", 32'(ocr8), 32'h40);
    cyc(1);
    check_eq("t3 ocr applied", 32'(ocr8), 32'h80);
    check_eq("t3 oc set2", 32'(oc8), 32'h1);
    cyc(65);
    check_eq("t3 oc past 40", 32'(oc8), 32'h1);
    cyc(64);
    check_eq("t3 at 81", 32'(tcnt8), 32'h81);
    check_eq("t3 oc clr2", 32'(oc8), 32'h0);

    // 6: asynchronous reset mid-count in PWM mode
    cyc(127);
    check_eq("t6 pre oc", 32'(oc8), 32'h1);
    cyc(5);
    rst_n = 1'b0;
    #2;
    check_all_zero8("t6 async");
    check_eq("t6 tcnt16", 32'(tcnt16), 32'h0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // 4: external clock, rising then falling edges
    do_reset();
    wr_tccr(8'h07);
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      ext_pin = ~ext_pin;
      cyc(2);
      check_eq($sformatf("t4r pre%0d", i), 32'(tcnt8), 32'(exp_cnt));
      cyc(1);
      if (ext_pin) exp_cnt++;
      check_eq($sformatf("t4r post%0d", i), 32'(tcnt8), 32'(exp_cnt));
      cyc(7);
    end
    wr_tccr(8'h06);
    for (int i = 0; i < 4; i++) begin
      ext_pin = ~ext_pin;
      cyc(2);
      check_eq($sformatf("t4f pre%0d", i), 32'(tcnt8), 32'(exp_cnt));
      cyc(1);
      if (!ext_pin) exp_cnt++;
      check_eq($sformatf("t4f post%0d", i), 32'(tcnt8), 32'(exp_cnt));
      cyc(7);
    end

    // 5: FOC, blocked compare, collisions
    do_reset();
    wr_tccr(8'h20);
    check_eq("t5 oc pre foc", 32'(oc8), 32'h0);
    wr_tccr(8'hA0);
    check_eq("t5 foc toggle", 32'(oc8), 32'h1);
    check_eq("t5 foc not stored", 32'(tccr8), 32'h20);
    check_eq("t5 foc no flag", 32'(tifr8), 32'h0);
    wr_ocr(16'h0030);
    wr_tcnt(16'h0030);
    wr_tccr(8'h21);
    cyc(1);
    check_eq("t5 blk cnt", 32'(tcnt8), 32'h31);
    check_eq("t5 blk no ocf", 32'(tifr8[1]), 32'h0);
    check_eq("t5 blk no toggle", 32'(oc8), 32'h1);
    wr_tcnt(16'h0020);
    check_eq("t5 wr beats tick", 32'(tcnt8), 32'h20);
    cyc(1);
    check_eq("t5 after wr", 32'(tcnt8), 32'h21);
    clear_count = 1'b1; tcnt_in = 16'h0055; tcnt_we = 1'b1;
    cyc(1);
    clear_count = 1'b0; tcnt_we = 1'b0;
    check_eq("t5 clr beats wr", 32'(tcnt8), 32'h00);
    cyc(1);
    check_eq("t5 after clr", 32'(tcnt8), 32'h01);
    wr_tcnt(16'h00FE);
    cyc(1);
    check_eq("t5 at ff", 32'(tcnt8), 32'hFF);
    wr_tifr(2'b01);
    check_eq("t5 set beats clr", 32'(tifr8[0]), 32'h1);
    wr_tifr(2'b01);
    check_eq("t5 plain clr", 32'(tifr8[0]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
